mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM: a Moore state machine that sequences fetch, decode and execute phases.
// Optional macro CTRL_BNE_EN adds bne (op=000101) through the BRANCH state and the BranchNe output.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
`ifdef CTRL_BNE_EN
  output logic       BranchNe,
`endif
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_dec_illegal;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE && w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state logic; unused codes 12-15 fall back to FETCH
  always_comb begin
    w_next        = FETCH;
    w_dec_illegal = 1'b0;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYP:      w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:       w_next = BRANCH;
`endif
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default: begin
            w_next        = FETCH;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  w_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:  w_next = FETCH;
      MEMWR:  w_next = mem_ready ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ALUWB:  w_next = FETCH;
      BRANCH: w_next = FETCH;
      ADDIEX: w_next = ADDIWB;
      ADDIWB: w_next = FETCH;
      JUMP:   w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  // Moore output decode; enables are gated by reset so nothing writes while it is asserted
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUOp    = 2'b00;
`ifdef CTRL_BNE_EN
    BranchNe = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
`ifdef CTRL_BNE_EN
        BranchNe = (op == OP_BNE);
`endif
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
    end
  end

  assign state      = r_state;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm, plus a hand-written check of reset asserted mid-MEMRD.
// Build with +define+CTRL_BNE_EN to cover the optional bne path.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       IRWrite, PCWrite, Branch, MemWrite, RegWrite;
  logic       IorD, MemtoReg, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic [3:0] state;
  logic       illegal_op;
  logic       bne_out;

  int errors = 0;
  int checks = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IorD       (IorD),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUOp      (ALUOp),
`ifdef CTRL_BNE_EN
    .BranchNe   (bne_out),
`endif
    .state      (state),
    .illegal_op (illegal_op)
  );

`ifndef CTRL_BNE_EN
  assign bne_out = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {IRW,PCW,Br,MW,RW, IorD,M2R,RD,ASA, ALUSrcB, PCSrc, ALUOp}
  localparam logic [14:0] C_FETCH0 = 15'b00000_0000_01_00_00;
  localparam logic [14:0] C_FETCH1 = 15'b11000_0000_01_00_00;
  localparam logic [14:0] C_DEC    = 15'b00000_0000_11_00_00;
  localparam logic [14:0] C_MADR   = 15'b00000_0001_10_00_00;
  localparam logic [14:0] C_MRD    = 15'b00000_1000_00_00_00;
  localparam logic [14:0] C_MWB    = 15'b00001_0100_00_00_00;
  localparam logic [14:0] C_MWR    = 15'b00010_1000_00_00_00;
  localparam logic [14:0] C_EXEC   = 15'b00000_0001_00_00_10;
  localparam logic [14:0] C_ALUWB  = 15'b00001_0010_00_00_00;
  localparam logic [14:0] C_BR     = 15'b00100_0001_00_01_01;
  localparam logic [14:0] C_ADDIEX = 15'b00000_0001_10_00_00;
  localparam logic [14:0] C_ADDIWB = 15'b00001_0000_00_00_00;
  localparam logic [14:0] C_JUMP   = 15'b01000_0000_00_10_00;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BNE = 6'b000101, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic        mr;
    logic [5:0]  opc;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic        ill;
    logic        bne;
  } vec_t;

  vec_t vq[$];

  logic [14:0] w_ctrl;
  assign w_ctrl = {IRWrite, PCWrite, Branch, MemWrite, RegWrite,
                   IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSrc, ALUOp};

  task automatic add(input logic rst, input logic mr, input logic [5:0] opc,
                     input logic [3:0] st, input logic [14:0] ctrl,
                     input logic ill, input logic bne);
    vec_t v;
    v.rst = rst; v.mr = mr; v.opc = opc; v.st = st;
    v.ctrl = ctrl; v.ill = ill; v.bne = bne;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st,
                       input logic [14:0] ctrl, input logic ill, input logic bne);
    checks++;
    if (state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, state, st);
    end
    checks++;
    if (w_ctrl !== ctrl) begin
      errors++;
      $display("FAIL %s ctrl: got %b expected %b", name, w_ctrl, ctrl);
    end
    checks++;
    if (illegal_op !== ill) begin
      errors++;
      $display("FAIL %s illegal_op: got %b expected %b", name, illegal_op, ill);
    end
    checks++;
    if (bne_out !== bne) begin
      errors++;
      $display("FAIL %s BranchNe: got %b expected %b", name, bne_out, bne);
    end
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    op = LW;

    // Reset held 3 cycles with mem_ready=1: enables must stay 0
    repeat (3) add(0, 1, LW, 0, C_FETCH0, 0, 0);
    // lw: 0,1,2,3,4,0
    add(1, 1, LW, 0, C_FETCH1, 0, 0);
    add(1, 1, LW, 1, C_DEC,    0, 0);
    add(1, 1, LW, 2, C_MADR,   0, 0);
    add(1, 1, LW, 3, C_MRD,    0, 0);
    add(1, 1, LW, 4, C_MWB,    0, 0);
    // sw with two wait cycles in MEMWR
    add(1, 1, SW, 0, C_FETCH1, 0, 0);
    add(1, 1, SW, 1, C_DEC,    0, 0);
    add(1, 0, SW, 2, C_MADR,   0, 0);
    add(1, 0, SW, 5, C_MWR,    0, 0);
    add(1, 0, SW, 5, C_MWR,    0, 0);
    add(1, 1, SW, 5, C_MWR,    0, 0);
    // FETCH stall 4 cycles, then R-type with mem_ready=0 where it is ignored
    repeat (4) add(1, 0, RT, 0, C_FETCH0, 0, 0);
    add(1, 1, RT, 0, C_FETCH1, 0, 0);
    add(1, 0, RT, 1, C_DEC,    0, 0);
    add(1, 0, RT, 6, C_EXEC,   0, 0);
    add(1, 0, RT, 7, C_ALUWB,  0, 0);
    // addi
    add(1, 1, ADDI, 0,  C_FETCH1, 0, 0);
    add(1, 1, ADDI, 1,  C_DEC,    0, 0);
    add(1, 1, ADDI, 9,  C_ADDIEX, 0, 0);
    add(1, 1, ADDI, 10, C_ADDIWB, 0, 0);
    // beq
    add(1, 1, BEQ, 0, C_FETCH1, 0, 0);
    add(1, 1, BEQ, 1, C_DEC,    0, 0);
    add(1, 0, BEQ, 8, C_BR,     0, 0);
    // j
    add(1, 1, J, 0,  C_FETCH1, 0, 0);
    add(1, 1, J, 1,  C_DEC,    0, 0);
    add(1, 0, J, 11, C_JUMP,   0, 0);
    // bne: branch when enabled, illegal otherwise
    add(1, 1, BNE, 0, C_FETCH1, 0, 0);
    add(1, 1, BNE, 1, C_DEC,    0, 0);
`ifdef CTRL_BNE_EN
    add(1, 0, BNE, 8, C_BR,     0, 1);
    add(1, 0, BNE, 0, C_FETCH0, 0, 0);
`else
    add(1, 0, BNE, 0, C_FETCH0, 1, 0);
`endif
    add(0, 1, BNE, 0, C_FETCH0, 0, 0);
    // Illegal opcode sets sticky flag, survives a following lw
    add(1, 1, BAD, 0, C_FETCH1, 0, 0);
    add(1, 1, BAD, 1, C_DEC,    0, 0);
    add(1, 1, LW,  0, C_FETCH1, 1, 0);
    add(1, 1, LW,  1, C_DEC,    1, 0);
    add(1, 1, LW,  2, C_MADR,   1, 0);
    add(1, 1, LW,  3, C_MRD,    1, 0);
    add(1, 1, LW,  4, C_MWB,    1, 0);
    add(1, 1, LW,  0, C_FETCH1, 1, 0);
    add(0, 1, LW,  0, C_FETCH0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst;
      mem_ready = vq[i].mr;
      op = vq[i].opc;
      #1;
      check($sformatf("vec%0d", i), vq[i].st, vq[i].ctrl, vq[i].ill, vq[i].bne);
    end

    // Reset asserted mid-MEMRD takes effect before the next clock edge
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; op = LW;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("pre_rst_memrd", 3, C_MRD, 0, 0);
    #2 reset = 1'b0;
    #1 check("async_rst", 0, C_FETCH0, 0, 0);
    @(negedge clk); reset = 1'b1;
    #1 check("post_rst_fetch", 0, C_FETCH1, 0, 0);
    @(negedge clk);
    #1 check("post_rst_decode", 1, C_DEC, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
